// File: rtl/tanh_input_conditioner.sv
// -----------------------------------------------------------------------------
// tanh_input_conditioner
//
// Converts signed fixed-point accumulator results from the MAC array into the
// Q5.5 format consumed by the tanh/sigmoid stage. Each sample is rounded
// half-up to the output LSB and saturated to +/-SAT_MAG. Two pipeline stages
// with valid/ready handshakes on both sides; saturation events are counted.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   accumulator sample valid
//   in_ready   block can accept a sample this cycle (combinational from out_ready)
//   in_data    signed accumulator value, ACC_INT_W.ACC_FRAC_W
//   out_valid  conditioned sample valid
//   out_ready  consumer accepts the sample
//   out_data   signed Q(OUT_INT_W).(OUT_FRAC_W) result, range -SAT_MAG..+SAT_MAG
//   out_sat    current out_data was saturated
//   sat_count  saturated samples since reset / last clear, sticks at all-ones
//   sat_clear  synchronous clear of sat_count (wins over a same-cycle increment)
// -----------------------------------------------------------------------------
module tanh_input_conditioner #(
    parameter int ACC_INT_W  = 10,
    parameter int ACC_FRAC_W = 10,
    parameter int OUT_INT_W  = 5,
    parameter int OUT_FRAC_W = 5,
    parameter logic [OUT_INT_W+OUT_FRAC_W-1:0] SAT_MAG = 10'b00111_00000,
    parameter int CNT_W      = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ACC_INT_W+ACC_FRAC_W-1:0]     in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_INT_W+OUT_FRAC_W-1:0]     out_data,
    output logic                                out_sat,
    output logic [CNT_W-1:0]                    sat_count,
    input  logic                                sat_clear
);

    localparam int IN_W  = ACC_INT_W + ACC_FRAC_W;
    localparam int OUT_W = OUT_INT_W + OUT_FRAC_W;
    localparam int SHIFT = ACC_FRAC_W - OUT_FRAC_W;
    // Rounded value keeps every integer bit of the sign-extended input.
    localparam int RW    = IN_W + 1 - SHIFT;

    // Half of one output LSB, expressed in input LSBs.
    localparam logic signed [IN_W:0]    ROUND_BIAS = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0]    POS_LIM    = {{(RW - OUT_W){1'b0}}, SAT_MAG};
    localparam logic signed [RW-1:0]    NEG_LIM    = -POS_LIM;
    localparam logic [OUT_W-1:0]        NEG_OUT    = NEG_LIM[OUT_W-1:0];

    // Pipeline state
    logic                     s1_valid_q;
    logic signed [RW-1:0]     s1_r_q;
    logic                     s2_valid_q;
    logic [OUT_W-1:0]         out_data_q;
    logic                     out_sat_q;
    logic [CNT_W-1:0]         sat_count_q;

    // Next-state / combinational
    logic                     s1_adv;
    logic                     s2_adv;
    logic signed [IN_W:0]     round_sum;
    logic signed [RW-1:0]     s1_r_d;
    logic [OUT_W-1:0]         out_data_d;
    logic                     out_sat_d;
    logic [CNT_W-1:0]         sat_count_d;
    logic                     unused_round_lsbs;

    // Each stage moves when its own register is empty or the stage after it
    // frees up this cycle; in_ready therefore sees out_ready combinationally.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // S1 rounding: sign-extend by one bit so the bias cannot overflow, add half
    // an output LSB, then drop SHIFT fraction bits (arithmetic shift via slice).
    assign round_sum         = $signed({in_data[IN_W-1], in_data}) + ROUND_BIAS;
    assign s1_r_d            = round_sum[IN_W:SHIFT];
    assign unused_round_lsbs = ^round_sum[SHIFT-1:0];

    // S2 saturation; exactly +/-SAT_MAG passes through unflagged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        out_data_d = s1_r_q[OUT_W-1:0];
        out_sat_d  = 1'b0;
        if (s1_r_q > POS_LIM) begin
            out_data_d = SAT_MAG;
            out_sat_d  = 1'b1;
        end else if (s1_r_q < NEG_LIM) begin
            out_data_d = NEG_OUT;
            out_sat_d  = 1'b1;
        end
    end

    // Saturation counter: counts S2 loads that saturate, sticks at all-ones,
    // clear takes priority over a same-cycle increment.
    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (s2_adv && s1_valid_q && out_sat_d && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are reset along with the valids so the
            // outputs read zero during and right after reset.
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others, independent of statement order.
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_r_q <= s1_r_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                // Data holds its last value when the stage empties.
                if (s1_valid_q) begin
                    out_data_q <= out_data_d;
                    out_sat_q  <= out_sat_d;
                end
            end
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_tanh_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_tanh_input_conditioner
//
// Self-checking bench for tanh_input_conditioner: directed vector table,
// sat_clear priority, backpressure stream, randomized traffic against a
// real-arithmetic reference model with a scoreboard, counter saturation and
// asynchronous reset in mid-stream.
// Inputs are driven and outputs sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tanh_input_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        out_sat;
    logic [15:0] sat_count;
    logic        sat_clear;

    always #5 clk = ~clk;

    tanh_input_conditioner dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count),
        .sat_clear (sat_clear)
    );

    typedef struct packed {
        logic       sat;
        logic [9:0] data;
    } res_t;

    typedef struct {
        logic [19:0] din;
        logic [9:0]  exp_data;
        logic        exp_sat;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    res_t  exp_q[$];
    int    model_sat_cnt = 0;
    logic  stall_q = 1'b0;
    res_t  stall_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value in output LSBs = floor(x/32 + 1/2), then clamp to +/-224.
    function automatic res_t model(input logic signed [19:0] x);
        real  q;
        int   r;
        res_t o;
        q = $floor((real'(x) + 16.0) / 32.0);
        r = int'(q);
        if (r > 224) begin
            o.sat = 1'b1; o.data = 10'(224);
        end else if (r < -224) begin
            o.sat = 1'b1; o.data = 10'(-224);
        end else begin
            o.sat = 1'b0; o.data = 10'(r);
        end
        return o;
    endfunction

    // One clock cycle with scoreboard tracking. Called at a falling edge,
    // returns at the next falling edge.
    task automatic step(input logic v, input logic [19:0] d, input logic rdy, output logic acc);
        res_t e;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
        acc = v && in_ready;
        if (stall_q) begin
            check("stall_valid_hold", out_valid, 1);
            check("stall_data_hold", {out_sat, out_data}, stall_r);
        end
        if (out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_sample", {out_sat, out_data}, e);
            end
        end
        stall_q = out_valid && !rdy;
        stall_r = {out_sat, out_data};
        if (acc) begin
            e = model(d);
            exp_q.push_back(e);
            if (e.sat && model_sat_cnt < 65535) model_sat_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        logic acc;
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) step(1'b0, 20'h0, 1'b1, acc);
        check("drain_empty", exp_q.size(), 0);
        step(1'b0, 20'h0, 1'b1, acc);
        step(1'b0, 20'h0, 1'b1, acc);
    endtask

    task automatic clear_cnt();
        logic acc;
        sat_clear = 1'b1;
        step(1'b0, 20'h0, 1'b1, acc);
        sat_clear = 1'b0;
        model_sat_cnt = 0;
    endtask

    // Single sample on an idle pipeline: not visible after one edge, valid after two.
    task automatic apply_single(input string name, input logic [19:0] d, input res_t exp_r);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        #1;
        check({name, "_accept"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({name, "_lat1"}, out_valid, 0);
        @(negedge clk);
        #1;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, {out_sat, out_data}, exp_r);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[15];
        logic        acc;
        int          exp_cnt;
        int          idx;
        int          cyc;
        logic        dropped;
        logic        pend;
        logic [19:0] d;
        int          v;

        vecs[0]  = '{20'h00E00, 10'h070, 1'b0};   // +3.5
        vecs[1]  = '{20'h00010, 10'h001, 1'b0};   // +16 LSB rounds up
        vecs[2]  = '{20'hFFFF0, 10'h000, 1'b0};   // -16 rounds toward +inf
        vecs[3]  = '{20'hFFFEF, 10'h3FF, 1'b0};   // -17
        vecs[4]  = '{20'h0000F, 10'h000, 1'b0};   // +15
        vecs[5]  = '{20'h02000, 10'h0E0, 1'b1};   // +8.0
        vecs[6]  = '{20'hFE000, 10'h320, 1'b1};   // -8.0
        vecs[7]  = '{20'h01C00, 10'h0E0, 1'b0};   // +7.0 exactly
        vecs[8]  = '{20'hFE400, 10'h320, 1'b0};   // -7.0 exactly
        vecs[9]  = '{20'h01C10, 10'h0E0, 1'b1};   // rounds to +225
        vecs[10] = '{20'hFE3F0, 10'h320, 1'b0};   // rounds to -224
        vecs[11] = '{20'hFE3EF, 10'h320, 1'b1};   // rounds to -225
        vecs[12] = '{20'h7FFFF, 10'h0E0, 1'b1};   // max positive
        vecs[13] = '{20'h80000, 10'h320, 1'b1};   // max negative
        vecs[14] = '{20'hFFFFF, 10'h000, 1'b0};   // -1 LSB

        // Reset state
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clear = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_count", sat_count, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        @(negedge clk);

        // Directed vector table
        exp_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            apply_single($sformatf("vec%0d", i), vecs[i].din, {vecs[i].exp_sat, vecs[i].exp_data});
            if (vecs[i].exp_sat) exp_cnt++;
        end
        check("table_sat_count", sat_count, exp_cnt);

        // sat_clear on the same edge a saturating sample loads S2
        in_valid = 1'b1; in_data = 20'h02000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        #1;
        check("clr_prio_out_sat", out_sat, 1);
        check("clr_prio_sat_count", sat_count, 0);
        @(negedge clk);

        // Backpressure: 10 incrementing samples, consumer stalls cycles 3..6
        idx = 0; cyc = 0; dropped = 1'b0;
        while (cyc < 40 && (idx < 10 || exp_q.size() > 0)) begin
            step(idx < 10, 20'((idx + 1) * 32), !(cyc >= 3 && cyc <= 6), acc);
            if (idx < 10 && !acc) dropped = 1'b1;
            if (acc) idx++;
            cyc++;
        end
        check("bp_in_ready_dropped", dropped, 1);
        check("bp_all_accepted", idx, 10);
        check("bp_all_emerged", exp_q.size(), 0);

        // Randomized traffic with held data while stalled
        clear_cnt();
        pend = 1'b0; d = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                case ($urandom_range(0, 3))
                    0: v = int'($urandom_range(0, 20'hFFFFF)) - 32'sh80000;
                    1: v = int'($urandom_range(0, 16'h2400));
                    2: v = 16'h1C00 + int'($urandom_range(0, 96)) - 48;
                    default: v = int'($urandom_range(0, 128));
                endcase
                if ($urandom_range(0, 1) == 1) v = -v;
                d = 20'(v);
            end
            pend = pend || ($urandom_range(0, 9) < 7);
            step(pend, d, $urandom_range(0, 9) < 6, acc);
            if (acc) pend = 1'b0;
        end
        in_valid = 1'b0;
        drain(20);
        check("rand_sat_count", sat_count, model_sat_cnt);

        // Counter saturation: 2^16+3 saturating samples
        clear_cnt();
        for (int i = 0; i < 65534; i++) step(1'b1, 20'h7FFFF, 1'b1, acc);
        drain(5);
        check("cnt_fffe", sat_count, 16'hFFFE);
        for (int i = 0; i < 5; i++) step(1'b1, 20'h80000, 1'b1, acc);
        drain(5);
        check("cnt_sticks_ffff", sat_count, 16'hFFFF);

        // Asynchronous reset with two samples in flight
        clear_cnt();
        step(1'b1, 20'h02000, 1'b1, acc);
        step(1'b1, 20'hFE000, 1'b0, acc);
        in_valid = 1'b0;
        #1;
        check("inflight_out_valid", out_valid, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_sat", out_sat, 0);
        check("async_rst_sat_count", sat_count, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        exp_q.delete();
        stall_q = 1'b0;
        model_sat_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_async_no_valid", out_valid, 0);
            step(1'b0, 20'h0, 1'b1, acc);
        end
        apply_single("post_async", 20'h00E00, model(20'h00E00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
